// File: rtl/wide_add_pkg.sv
// Shared definitions for the byte-serial wide adder: datapath byte width and sequencer states.
package wide_add_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } wa_state_t;

endpackage

// File: rtl/byte_add_cla.sv
// 8-bit carry-lookahead adder slice; also exposes the carry into bit 7 for signed-overflow detection.
module byte_add_cla
   import wide_add_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              c_in,
   output logic [BYTE_W-1:0] sum,
   output logic              c_out,
   output logic              c7
);

   logic [BYTE_W-1:0] g;
   logic [BYTE_W-1:0] p;
   logic [BYTE_W:0]   c;

   always_comb begin : carry_gen
      logic acc;
      // NOTE: every variable gets a value before any conditional/loop logic, so no path can infer a latch.
      g   = a & b;
      p   = a ^ b;
      c   = '0;
      acc = 1'b0;
      c[0] = c_in;
      // Each carry is expanded from g/p and c_in alone, not from the previous carry signal.
      for (int i = 0; i < BYTE_W; i++) begin
         acc = c_in;
         for (int j = 0; j <= i; j++) begin
            acc = g[j] | (p[j] & acc);
         end
         c[i+1] = acc;
      end
      sum   = p ^ c[BYTE_W-1:0];
      c_out = c[BYTE_W];
      c7    = c[BYTE_W-1];
   end

endmodule

// File: rtl/wide_add_seq.sv
// Byte-serial WIDTH-bit add/subtract sequencer around one 8-bit CLA slice, LSB byte first.
// Optional SATURATE_EN: clamp the result to the signed extreme on overflow instead of wrapping.
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovfl,
   output logic             zero,
   output logic             busy
);

   localparam int NBYTES = WIDTH / BYTE_W;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   wa_state_t         state;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              carry_q;
   logic [IDX_W-1:0]  idx_q;

   logic [BYTE_W-1:0] a_byte;
   logic [BYTE_W-1:0] b_byte;
   logic [BYTE_W-1:0] sum_byte;
   logic              c_out;
   logic              c7;
   logic              last;
   logic              ovfl_nxt;
   logic [WIDTH-1:0]  result_nxt;
   logic              accept;

   assign accept = in_valid & in_ready;
   assign last   = (idx_q == LAST_IDX);
   assign a_byte = a_q[idx_q*BYTE_W +: BYTE_W];
   assign b_byte = b_q[idx_q*BYTE_W +: BYTE_W];

   byte_add_cla u_cla (
      .a     (a_byte),
      .b     (b_byte),
      .c_in  (carry_q),
      .sum   (sum_byte),
      .c_out (c_out),
      .c7    (c7)
   );

   // Only meaningful on the last byte, where c7/c_out belong to the operand MSB.
   assign ovfl_nxt = c7 ^ c_out;

   always_comb begin
      result_nxt = result;
      result_nxt[idx_q*BYTE_W +: BYTE_W] = sum_byte;
`ifdef SATURATE_EN
      if (last && ovfl_nxt) begin
         result_nxt = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
      end
`endif
   end

   // NOTE: operand registers carry no reset; they are always loaded on accept before being read.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= op_a;
         b_q <= op_b ^ {WIDTH{op_sub}};
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
         ovfl      <= 1'b0;
         zero      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= RUN;
                  idx_q    <= '0;
                  carry_q  <= op_sub;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               result  <= result_nxt;
               carry_q <= c_out;
               idx_q   <= idx_q + 1'b1;
               if (last) begin
                  state     <= DONE;
                  cout      <= c_out;
                  ovfl      <= ovfl_nxt;
                  zero      <= (result_nxt == '0);
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
